// File: rtl/sad_instr_issuer_pkg.sv
// Shared opcodes, state encoding and I-type packing for the SAD-extension issuer and decoder.
package sad_instr_issuer_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned INSTR_W = 32;

    localparam logic [5:0] OP_LBUFA   = 6'b010011;
    localparam logic [5:0] OP_LBUFB   = 6'b110011;
    localparam logic [5:0] OP_SAD_B   = 6'b010110;
    localparam logic [5:0] OP_LMIN    = 6'b111001;
    localparam logic [5:0] OP_LTAG    = 6'b110111;
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] FUNCT_ABUF = 6'b010111;

    localparam logic [INSTR_W-1:0] ABUF_WORD = {OP_RTYPE, 20'h0_0000, FUNCT_ABUF};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_BARRIER,
        ST_SCAN,
        ST_LMIN,
        ST_LTAG
    } state_t;

    typedef struct packed {
        logic [5:0]       opcode;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [IMM_W-1:0] imm;
    } itype_t;

    function automatic logic [INSTR_W-1:0] pack_itype(input logic [5:0]       op,
                                                      input logic [REG_W-1:0] rs,
                                                      input logic [IMM_W-1:0] imm);
        itype_t w;
        w.opcode = op;
        w.rs     = rs;
        w.rt     = '0;
        w.imm    = imm;
        return w;
    endfunction

endpackage

// File: rtl/sad_imm_gen.sv
// Combinational immediate generator: row offsets for buffer loads, shifted frame offsets for the scan.
module sad_imm_gen
    import sad_instr_issuer_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned STRIDE     = 64,
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned ROW_W      = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  state_t             state,
    input  logic [ROW_W-1:0]   row,
    input  logic [CNT_W-1:0]   k,
    output logic [IMM_W-1:0]   imm
);

    // Offsets are formed in 32 bits and truncated; wrap is intentional.
    always_comb begin
        imm = '0;
        case (state)
            ST_LOAD_A, ST_LOAD_B: imm = IMM_W'(32'(row) * STRIDE);
            ST_SCAN:              imm = IMM_W'(ROWS * STRIDE + 32'(k) * SHIFT_STEP);
            default:              imm = '0;
        endcase
    end

endmodule

// File: rtl/sad_instr_issuer.sv
// Issues the LBUFA/LBUFB/SAD_B/LMIN/LTAG stream of one block-search pass under ID_stall backpressure.
// Build option: SAD_ISSUE_BARRIER_EN inserts an ABUF barrier word between LOAD_B and SCAN/LMIN.
module sad_instr_issuer
    import sad_instr_issuer_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned STRIDE     = 64,
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [REG_W-1:0]   win_reg,
    input  logic [REG_W-1:0]   frame_reg,
    input  logic [CNT_W-1:0]   n_shifts,
    input  logic               ID_stall,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned ROW_W = $clog2(ROWS + 1);

    state_t             state, nxt_state;
    logic [ROW_W-1:0]   row, nxt_row;
    logic [CNT_W-1:0]   k, nxt_k;
    logic [REG_W-1:0]   win_q, frame_q, rs_win;
    logic [CNT_W-1:0]   n_q;
    logic               accept, nxt_done;
    logic [IMM_W-1:0]   nxt_imm;
    logic [INSTR_W-1:0] nxt_word;

    assign accept = instr_valid & ~ID_stall;

    // Position of the word to present after this edge; a stall leaves it unchanged.
    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_k     = k;
        nxt_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    nxt_state = ST_LOAD_A;
                    nxt_row   = '0;
                end
            end
            ST_LOAD_A: begin
                if (accept) begin
                    if (row == ROW_W'(ROWS - 1)) begin
                        nxt_state = ST_LOAD_B;
                        nxt_row   = '0;
                    end else begin
                        nxt_row = row + ROW_W'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (accept) begin
                    if (row == ROW_W'(ROWS - 1)) begin
                        nxt_row = '0;
                        nxt_k   = '0;
`ifdef SAD_ISSUE_BARRIER_EN
                        nxt_state = ST_BARRIER;
`else
                        nxt_state = (n_q == '0) ? ST_LMIN : ST_SCAN;
`endif
                    end else begin
                        nxt_row = row + ROW_W'(1);
                    end
                end
            end
`ifdef SAD_ISSUE_BARRIER_EN
            ST_BARRIER: begin
                if (accept) begin
                    nxt_k     = '0;
                    nxt_state = (n_q == '0) ? ST_LMIN : ST_SCAN;
                end
            end
`endif
            ST_SCAN: begin
                if (accept) begin
                    if (k == n_q - CNT_W'(1)) begin
                        nxt_state = ST_LMIN;
                        nxt_k     = '0;
                    end else begin
                        nxt_k = k + CNT_W'(1);
                    end
                end
            end
            ST_LMIN: begin
                if (accept) nxt_state = ST_LTAG;
            end
            ST_LTAG: begin
                if (accept) begin
                    nxt_state = ST_IDLE;
                    nxt_done  = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (abort) begin
            nxt_state = ST_IDLE;
            nxt_row   = '0;
            nxt_k     = '0;
            nxt_done  = 1'b0;
        end
    end

    sad_imm_gen #(
        .ROWS       (ROWS),
        .STRIDE     (STRIDE),
        .SHIFT_STEP (SHIFT_STEP),
        .ROW_W      (ROW_W),
        .CNT_W      (CNT_W)
    ) u_imm_gen (
        .state (nxt_state),
        .row   (nxt_row),
        .k     (nxt_k),
        .imm   (nxt_imm)
    );

    // The first LBUFA is built on the start edge, before win_q holds the latched value.
    assign rs_win = (state == ST_IDLE) ? win_reg : win_q;

    always_comb begin
        nxt_word = '0;
        case (nxt_state)
            ST_LOAD_A:  nxt_word = pack_itype(OP_LBUFA, rs_win, nxt_imm);
            ST_LOAD_B:  nxt_word = pack_itype(OP_LBUFB, frame_q, nxt_imm);
            ST_BARRIER: nxt_word = ABUF_WORD;
            ST_SCAN:    nxt_word = pack_itype(OP_SAD_B, frame_q, nxt_imm);
            ST_LMIN:    nxt_word = pack_itype(OP_LMIN, '0, '0);
            ST_LTAG:    nxt_word = pack_itype(OP_LTAG, '0, '0);
            default:    nxt_word = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            row         <= '0;
            k           <= '0;
            win_q       <= '0;
            frame_q     <= '0;
            n_q         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= nxt_state;
            row   <= nxt_row;
            k     <= nxt_k;
            if (state == ST_IDLE && start && !abort) begin
                win_q   <= win_reg;
                frame_q <= frame_reg;
                n_q     <= n_shifts;
            end
            instr       <= nxt_word;
            instr_valid <= (nxt_state != ST_IDLE);
            busy        <= (nxt_state != ST_IDLE);
            done        <= nxt_done;
        end
    end

endmodule

// File: tb/tb_sad_instr_issuer.sv
// Randomized self-checking bench for sad_instr_issuer against a queue-based expected instruction stream.
module tb_sad_instr_issuer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start, abort, ID_stall;
    logic [4:0]  win_reg, frame_reg;
    logic [7:0]  n_shifts;
    logic [31:0] instr;
    logic        instr_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q[$];

    sad_instr_issuer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .abort       (abort),
        .win_reg     (win_reg),
        .frame_reg   (frame_reg),
        .n_shifts    (n_shifts),
        .ID_stall    (ID_stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected stream of one pass, straight from the instruction-format rules.
    task automatic build(input logic [4:0] w, input logic [4:0] f, input logic [7:0] n);
        q.delete();
        for (int r = 0; r < 4; r++) q.push_back({6'b010011, w, 5'd0, 16'(r * 64)});
        for (int r = 0; r < 4; r++) q.push_back({6'b110011, f, 5'd0, 16'(r * 64)});
`ifdef SAD_ISSUE_BARRIER_EN
        q.push_back(32'h0000_0017);
`endif
        for (int s = 0; s < int'(n); s++) q.push_back({6'b010110, f, 5'd0, 16'(256 + s * 4)});
        q.push_back(32'hE400_0000);
        q.push_back(32'hDC00_0000);
    endtask

    // mode 0: no stall, 1: random stall, 2: 5 stalls on 2nd LBUFA, 3: 7 stalls on barrier word
    task automatic run_pass(input logic [4:0] w, input logic [4:0] f, input logic [7:0] n,
                            input int mode);
        int stalls = 0, idx = 0, cyc = 0, valid_cycles = 0, exp_len;
        logic stall;
        build(w, f, n);
        exp_len   = q.size();
        win_reg   = w;
        frame_reg = f;
        n_shifts  = n;
        start     = 1'b1;
        abort     = 1'b0;
        ID_stall  = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        while (q.size() > 0 && cyc < 400) begin
            chk("valid_in_pass", 32'(instr_valid), 32'd1);
            chk("busy_in_pass", 32'(busy), 32'd1);
            chk("done_in_pass", 32'(done), 32'd0);
            chk("instr_word", instr, q[0]);
            if (mode == 2 && idx == 1 && w == 5'd0) chk("stall_hold", instr, 32'h4C00_0040);
            if (mode == 3 && idx == 8) chk("barrier_word", instr, 32'h0000_0017);
            stall = 1'b0;
            case (mode)
                1: stall = ($urandom_range(0, 2) == 0);
                2: stall = (idx == 1 && stalls < 5);
                3: stall = (idx == 8 && stalls < 7);
                default: stall = 1'b0;
            endcase
            if (stall) stalls++;
            ID_stall = stall;
            if (!stall) begin
                void'(q.pop_front());
                idx++;
            end
            valid_cycles++;
            win_reg   = 5'($urandom);
            frame_reg = 5'($urandom);
            n_shifts  = 8'($urandom);
            start     = 1'($urandom_range(0, 1));
            @(negedge Clk);
            cyc++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL pass_timeout: %0d words left, required 0", q.size());
        end
        ID_stall = 1'b0;
        start    = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_after", 32'(instr_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("instr_after", instr, 32'h0);
        chk("valid_cycles", 32'(valid_cycles), 32'(exp_len + stalls));
        @(negedge Clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] target;
        int cyc;
        Reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ID_stall  = 1'b0;
        win_reg   = '0;
        frame_reg = '0;
        n_shifts  = '0;
        #3;
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_pass(5'd0, 5'd0, 8'd3, 0);
        run_pass(5'd0, 5'd2, 8'd2, 2);
        run_pass(5'd7, 5'd9, 8'd0, 0);
`ifdef SAD_ISSUE_BARRIER_EN
        run_pass(5'd1, 5'd3, 8'd1, 3);
`endif
        for (int i = 0; i < 6; i++)
            run_pass(5'($urandom), 5'($urandom), 8'($urandom_range(0, 6)), 1);

        // Abort during SCAN, on the same edge that accepts SAD_B k=1.
        target    = {6'b010110, 5'd9, 5'd0, 16'd260};
        win_reg   = 5'd4;
        frame_reg = 5'd9;
        n_shifts  = 8'd3;
        start     = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        cyc   = 0;
        while (!(instr_valid === 1'b1 && instr === target) && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        chk("abort_reach_k1", instr, target);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("abort_valid", 32'(instr_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_instr", instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            @(negedge Clk);
        end
        run_pass(5'd0, 5'd1, 8'd2, 0);

        // Asynchronous reset in the middle of LOAD_B.
        win_reg   = 5'd3;
        frame_reg = 5'd6;
        n_shifts  = 8'd2;
        start     = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        cyc   = 0;
        while (instr[31:26] !== 6'b110011 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        @(negedge Clk);
        chk("reach_load_b", 32'(instr[31:26]), 32'(6'b110011));
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_instr", instr, 32'h0);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_valid", 32'(instr_valid), 32'd0);
        chk("start_abort_busy", 32'(busy), 32'd0);
        @(negedge Clk);
        chk("start_abort_idle", 32'(instr_valid), 32'd0);
        chk("start_abort_instr", instr, 32'h0);
        run_pass(5'd2, 5'd5, 8'd1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
